// File: rtl/desired_drive_pipe.sv
// Desired-drive target current: torque x incline x cadence x assist on one shared
// multiplier over three cycles, then a slew-limited, registered output.
module desired_drive_pipe #(
  parameter int TORQUE_W   = 12,
  parameter int INCL_W     = 13,
  parameter int CAD_W      = 5,
  parameter int SCALE_W    = 3,
  parameter int OUT_W      = 12,
  parameter int TORQUE_MIN = 'h380,
  parameter int CAD_MIN    = 2,
  parameter int PROD_SHIFT = 15,
  parameter int SLEW_STEP  = 'h100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  input  logic [TORQUE_W-1:0]      avg_torque,
  input  logic [CAD_W-1:0]         cadence,
  input  logic                     not_pedaling,
  input  logic signed [INCL_W-1:0] incline,
  input  logic [SCALE_W-1:0]       scale,
  output logic                     busy,
  output logic                     vld_out,
  output logic [OUT_W-1:0]         target_curr
);
  localparam int P_W  = TORQUE_W + 9 + CAD_W + 1 + SCALE_W;
  localparam int MB_A = (CAD_W + 1 > 9) ? CAD_W + 1 : 9;
  localparam int MB_W = (SCALE_W > MB_A) ? SCALE_W : MB_A;
  localparam logic signed [INCL_W-1:0] INCL_HI = INCL_W'(511);
  localparam logic signed [INCL_W-1:0] INCL_LO = INCL_W'(-512);
  localparam logic [OUT_W:0] STEP_W = (OUT_W+1)'(SLEW_STEP);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, SLEW} state_t;
  state_t state, state_nx;

  logic [TORQUE_W-1:0]      torque_q;
  logic [CAD_W-1:0]         cad_q;
  logic                     np_q;
  logic signed [INCL_W-1:0] incl_q;
  logic [SCALE_W-1:0]       scale_q;
  logic [P_W-1:0]           p_q;

  logic [9:0]          incl_sat;
  logic [10:0]         incl_off;
  logic [8:0]          incl_lim;
  logic [CAD_W:0]      cad_factor;
  logic [TORQUE_W-1:0] torque_pos;
  logic [P_W-1:0]      mul_a, mul_prod;
  logic [MB_W-1:0]     mul_b;
  logic [OUT_W-1:0]    raw, target_nx;
  logic [OUT_W:0]      raw_w, tgt_w;

  // Operand conditioning from the captured sample
  always_comb begin
    if (incl_q > INCL_HI)      incl_sat = 10'h1FF;
    else if (incl_q < INCL_LO) incl_sat = 10'h200;
    else                       incl_sat = incl_q[9:0];
    incl_off = {incl_sat[9], incl_sat} + 11'd256;
    if (incl_off[10])     incl_lim = 9'd0;
    else if (incl_off[9]) incl_lim = 9'h1FF;
    else                  incl_lim = incl_off[8:0];
    cad_factor = (cad_q >= CAD_W'(CAD_MIN)) ? {1'b1, cad_q} : '0;
    torque_pos = (torque_q > TORQUE_W'(TORQUE_MIN)) ? torque_q - TORQUE_W'(TORQUE_MIN) : '0;
  end

  // Shared multiplier: first pass seeds from torque, later passes accumulate into p_q
  always_comb begin
    mul_a = p_q;
    mul_b = '0;
    case (state)
      MUL1: begin
        mul_a = P_W'(torque_pos);
        mul_b = MB_W'(incl_lim);
      end
      MUL2:    mul_b = MB_W'(cad_factor);
      MUL3:    mul_b = MB_W'(scale_q);
      default: mul_b = '0;
    endcase
    mul_prod = mul_a * {{(P_W-MB_W){1'b0}}, mul_b};
  end

  always_comb begin
    if (np_q)                              raw = '0;
    else if (|p_q[P_W-1:PROD_SHIFT+OUT_W]) raw = '1;
    else                                   raw = p_q[PROD_SHIFT+OUT_W-1:PROD_SHIFT];
    raw_w = {1'b0, raw};
    tgt_w = {1'b0, target_curr};
    if (np_q)
      target_nx = '0;
    else if (raw_w > tgt_w)
      target_nx = (raw_w - tgt_w <= STEP_W) ? raw : target_curr + OUT_W'(SLEW_STEP);
    else
      target_nx = (tgt_w - raw_w <= STEP_W) ? raw : target_curr - OUT_W'(SLEW_STEP);
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = vld_in ? MUL1 : IDLE;
      MUL1:    state_nx = MUL2;
      MUL2:    state_nx = MUL3;
      MUL3:    state_nx = SLEW;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      torque_q    <= '0;
      cad_q       <= '0;
      np_q        <= 1'b0;
      incl_q      <= '0;
      scale_q     <= '0;
      p_q         <= '0;
      vld_out     <= 1'b0;
      target_curr <= '0;
    end else begin
      state   <= state_nx;
      vld_out <= (state == SLEW);
      if (state == IDLE && vld_in) begin
        torque_q <= avg_torque;
        cad_q    <= cadence;
        np_q     <= not_pedaling;
        incl_q   <= incline;
        scale_q  <= scale;
      end
      if (state == MUL1 || state == MUL2 || state == MUL3)
        p_q <= mul_prod;
      if (state == SLEW)
        target_curr <= target_nx;
    end
  end
endmodule

// File: tb/tb_desired_drive_pipe.sv
// Directed + random bench for desired_drive_pipe against an arithmetic reference model.
module tb_desired_drive_pipe;
  logic              clk = 1'b0;
  logic              rst;
  logic              vld_in;
  logic [11:0]       avg_torque;
  logic [4:0]        cadence;
  logic              not_pedaling;
  logic signed [12:0] incline;
  logic [2:0]        scale;
  logic              busy, vld_out;
  logic [11:0]       target_curr;

  int nassert = 0;
  int nfail   = 0;
  int mtgt    = 0;

  always #5 clk = ~clk;

  desired_drive_pipe dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .avg_torque(avg_torque), .cadence(cadence),
    .not_pedaling(not_pedaling), .incline(incline), .scale(scale),
    .busy(busy), .vld_out(vld_out), .target_curr(target_curr)
  );

  function automatic int ref_raw(int tq, int cd, bit np, int inc, int sc);
    longint p;
    int s, l, tp, cf;
    if (np) return 0;
    s  = (inc > 511) ? 511 : ((inc < -512) ? -512 : inc);
    l  = s + 256;
    if (l < 0)   l = 0;
    if (l > 511) l = 511;
    tp = (tq > 'h380) ? tq - 'h380 : 0;
    cf = (cd >= 2) ? cd + 32 : 0;
    p  = longint'(tp) * l * cf * sc;
    p  = p / 32768;
    if (p > 4095) p = 4095;
    return int'(p);
  endfunction

  function automatic int ref_slew(int cur, int raw, bit np);
    if (np) return 0;
    if (raw - cur <= 256 && cur - raw <= 256) return raw;
    return (raw > cur) ? cur + 256 : cur - 256;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    avg_torque   = 12'($urandom);
    cadence      = 5'($urandom);
    not_pedaling = 1'($urandom);
    incline      = 13'($urandom);
    scale        = 3'($urandom);
  endtask

  // Called just after a negedge; leaves the bench just after the vld_out negedge.
  task automatic sample(int tq, int cd, bit np, int inc, int sc, bit hold);
    int prev, im;
    logic [12:0] inc13;
    inc13 = inc[12:0];
    im = int'($signed(inc13));
    avg_torque = tq[11:0]; cadence = cd[4:0]; not_pedaling = np;
    incline = inc13; scale = sc[2:0]; vld_in = 1'b1;
    prev = mtgt;
    mtgt = ref_slew(mtgt, ref_raw(tq & 'hFFF, cd & 'h1F, np, im, sc & 7), np);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check("busy", 32'(busy), 32'd1);
        check("vld_out_early", 32'(vld_out), 32'd0);
        check("target_hold", 32'(target_curr), 32'(prev));
        scramble();
        vld_in = hold ? 1'b1 : 1'($urandom);
      end else begin
        check("vld_out", 32'(vld_out), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("target", 32'(target_curr), 32'(mtgt));
        vld_in = 1'b0;
      end
    end
  endtask

  task automatic idle(int n);
    vld_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      scramble();
      @(negedge clk);
      check("idle_vld_out", 32'(vld_out), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_target", 32'(target_curr), 32'(mtgt));
    end
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0;
    avg_torque = '0; cadence = '0; not_pedaling = 1'b0; incline = '0; scale = '0;
    #12;
    check("rst_target", 32'(target_curr), 32'd0);
    check("rst_vld_out", 32'(vld_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1: ramp from 0 to 0x930 in 0x100 steps
    for (int k = 0; k < 10; k++) sample('h700, 16, 1'b0, 0, 7, 1'b0);
    check("t1_final", 32'(target_curr), 32'h930);
    // 3: not pedaling drops straight to 0
    sample('h700, 16, 1'b1, 0, 7, 1'b0);
    check("t3_zero", 32'(target_curr), 32'd0);
    // 2: overflow saturates, ramps by 0x100
    for (int k = 0; k < 3; k++) sample('hFFF, 31, 1'b0, 'h0FFF, 7, 1'b0);
    check("t2_ramp", 32'(target_curr), 32'h300);
    // 4: each zeroing input ramps down
    sample('h700, 1, 1'b0, 0, 7, 1'b0);
    sample('h37F, 16, 1'b0, 0, 7, 1'b0);
    sample('h700, 16, 1'b0, -'h1000, 7, 1'b0);
    sample('h700, 16, 1'b0, 0, 0, 1'b0);
    check("t4_floor", 32'(target_curr), 32'd0);
    idle(3);
    // 5: vld_in held high; busy strobes dropped, back-to-back accepts
    for (int k = 0; k < 4; k++) sample('h900, 20, 1'b0, 100, 5, 1'b1);

    // 6: reset during MUL2
    avg_torque = 12'hFFF; cadence = 5'd31; not_pedaling = 1'b0; incline = 13'd300;
    scale = 3'd7; vld_in = 1'b1;
    @(posedge clk);
    vld_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    mtgt = 0;
    check("t6_target", 32'(target_curr), 32'd0);
    check("t6_vld_out", 32'(vld_out), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    sample('h700, 16, 1'b0, 0, 7, 1'b0);
    check("t6_resume", 32'(target_curr), 32'h100);

    // random samples with random gaps
    for (int k = 0; k < 40; k++) begin
      sample(int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 8191)),
             int'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
